// File: rtl/uart_n_rx_pkg.sv
// uart_n_rx_pkg
// Shared definitions for the multi-byte UART receive path: frame-level and
// byte-level state encodings, the byte limit and the default bit period
// shared with the transmit side.
package uart_n_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RECV = 2'b01,
    S_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    R_HUNT  = 2'b00,
    R_START = 2'b01,
    R_DATA  = 2'b10,
    R_STOP  = 2'b11
  } rx_state_t;

  localparam int MAX_BYTES            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Requested byte count limited to what fits in the 64-bit buffer.
  function automatic logic [3:0] clamp_num(input logic [3:0] n);
    return (n > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : n;
  endfunction

endpackage

// File: rtl/uart_read_d.sv
// uart_read_d
// Two-flop RX synchroniser plus single-byte 8N1 receiver.
// Ports:
//   Clock  in   system clock, rising edge
//   Reset  in   asynchronous active-low reset
//   RX     in   serial line, idles high, asynchronous to Clock
//   valid  out  one-cycle pulse after the stop bit is sampled
//   data   out  received byte (LSB arrives first)
//   ferr   out  stop bit was 0; qualified by valid
//
// state   | meaning
// R_HUNT  | waiting for a falling edge on the synchronised line
// R_START | half a bit in; confirm start bit is still low
// R_DATA  | sampling 8 data bits at bit centres
// R_STOP  | sampling the stop bit, then report and re-hunt
module uart_read_d
  import uart_n_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       RX,
  output logic       valid,
  output logic [7:0] data,
  output logic       ferr
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  rx_state_t     rstate;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      rstate  <= R_HUNT;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      valid   <= 1'b0;
      data    <= '0;
      ferr    <= 1'b0;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      valid   <= 1'b0;
      case (rstate)
        R_HUNT: begin
          if (rx_prev && !rx_s) begin
            cnt    <= HALF;
            rstate <= R_START;
          end
        end
        R_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            rstate <= R_HUNT;          // glitch, not a real start bit
          end else begin
            cnt     <= FULL;
            bit_idx <= '0;
            rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= FULL;
            if (bit_idx == 3'd7) rstate <= R_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        R_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            valid  <= 1'b1;
            data   <= shreg;
            ferr   <= ~rx_s;
            rstate <= R_HUNT;
          end
        end
        default: rstate <= R_HUNT;
      endcase
    end
  end

endmodule

// File: rtl/uart_n_rx.sv
// uart_n_rx
// Multi-byte UART receiver. A rising edge on trig_in arms it to collect
// num (1..8, clamped) bytes; the first byte lands in the most significant
// populated byte of buffer, the last in buffer[7:0].
// Optional macro UART_N_RX_TIMEOUT_EN adds an inter-byte timeout and the
// timeout output.
// Ports:
//   Clock      in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   RX         in   serial line
//   num[3:0]   in   byte count, sampled on arm
//   trig_in    in   arm request (rising edge)
//   buffer     out  received bytes, right-aligned
//   done       out  one-cycle frame-complete pulse
//   frame_err  out  sticky: a byte with a bad stop bit was seen this frame
//   idle       out  Reset & (state == S_IDLE)
//   timeout    out  (macro only) sticky until next arm: frame aborted
//
// state  | meaning
// S_IDLE | waiting for arm; incoming bytes discarded
// S_RECV | collecting bytes until tarn reaches 0
// S_DONE | pulse done, return to idle
module uart_n_rx
  import uart_n_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
`ifdef UART_N_RX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        RX,
  input  logic [3:0]  num,
  input  logic        trig_in,
  output logic [63:0] buffer,
  output logic        done,
  output logic        frame_err,
  output logic        idle
`ifdef UART_N_RX_TIMEOUT_EN
  , output logic      timeout
`endif
);

  state_t     state;
  logic       pre_trig;
  logic       trig;
  logic [3:0] tarn;
  logic       valid;
  logic [7:0] data;
  logic       ferr;

  assign trig = trig_in & ~pre_trig;
  assign idle = Reset & (state == S_IDLE);

  uart_read_d #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_read (
    .Clock (Clock),
    .Reset (Reset),
    .RX    (RX),
    .valid (valid),
    .data  (data),
    .ferr  (ferr)
  );

`ifdef UART_N_RX_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
  logic        tmo_run;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      pre_trig  <= 1'b0;
      tarn      <= '0;
      buffer    <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_N_RX_TIMEOUT_EN
      tmo_cnt   <= '0;
      tmo_run   <= 1'b0;
      timeout   <= 1'b0;
`endif
    end else begin
      pre_trig <= trig_in;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trig) begin
            tarn      <= clamp_num(num);
            buffer    <= '0;
            frame_err <= 1'b0;
            state     <= S_RECV;
`ifdef UART_N_RX_TIMEOUT_EN
            tmo_cnt   <= '0;
            tmo_run   <= 1'b0;
            timeout   <= 1'b0;
`endif
          end
        end
        S_RECV: begin
          if (tarn == 4'd0) begin
            state <= S_DONE;
          end else if (valid) begin
            if (ferr) begin
              frame_err <= 1'b1;
            end else begin
              buffer <= {buffer[55:0], data};
              tarn   <= tarn - 4'd1;
              // Last byte goes straight to S_DONE so done trails valid by 2.
              if (tarn == 4'd1) state <= S_DONE;
            end
`ifdef UART_N_RX_TIMEOUT_EN
            tmo_cnt <= '0;
            if (!ferr) tmo_run <= 1'b1;
`endif
          end
`ifdef UART_N_RX_TIMEOUT_EN
          else if (tmo_run) begin
            if (tmo_cnt == TMO_LAST) begin
              timeout <= 1'b1;
              state   <= S_DONE;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
`endif
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_n_rx.sv
module tb_uart_n_rx;

  localparam int CPB = 8;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        RX = 1'b1;
  logic [3:0]  num = 4'd0;
  logic        trig_in = 1'b0;
  logic [63:0] buffer;
  logic        done;
  logic        frame_err;
  logic        idle;
`ifdef UART_N_RX_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int d0;

  uart_n_rx #(
    .CLKS_PER_BIT(CPB)
`ifdef UART_N_RX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .RX        (RX),
    .num       (num),
    .trig_in   (trig_in),
    .buffer    (buffer),
    .done      (done),
    .frame_err (frame_err),
    .idle      (idle)
`ifdef UART_N_RX_TIMEOUT_EN
    , .timeout (timeout)
`endif
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (CPB) @(posedge Clock);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(posedge Clock);
    end
    RX = stop;
    repeat (CPB) @(posedge Clock);
    RX = 1'b1;
    repeat (2 * CPB) @(posedge Clock);
  endtask

  // trig_in rises 1 time unit after an edge; the next edge is the arm edge.
  task automatic arm(input logic [3:0] n);
    @(posedge Clock); #1;
    num = n;
    trig_in = 1'b1;
    @(posedge Clock); #1;
    trig_in = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check("rst_buffer", buffer, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_ferr", {63'h0, frame_err}, 64'h0);
    check("rst_idle", {63'h0, idle}, 64'h0);
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("idle_after_rst", {63'h0, idle}, 64'h1);

    // 1: three bytes
    d0 = done_cnt;
    arm(4'd3);
    check("t1_busy", {63'h0, idle}, 64'h0);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    check("t1_buffer", buffer, 64'h0000_0000_00A1_B2C3);
    check("t1_ferr", {63'h0, frame_err}, 64'h0);
    check("t1_idle", {63'h0, idle}, 64'h1);
    check("t1_done_once", 64'(done_cnt - d0), 64'd1);

    // 2: eight bytes
    d0 = done_cnt;
    arm(4'd8);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    check("t2_buffer", buffer, 64'h0102_0304_0506_0708);
    check("t2_done_once", 64'(done_cnt - d0), 64'd1);

    // 3: num = 0, exact latency
    arm(4'd0);
    check("t3_buffer_clr", buffer, 64'h0);
    check("t3_done_e0", {63'h0, done}, 64'h0);
    @(posedge Clock); #1;
    check("t3_done_e1", {63'h0, done}, 64'h0);
    @(posedge Clock); #1;
    check("t3_done_e2", {63'h0, done}, 64'h1);
    @(posedge Clock); #1;
    check("t3_done_e3", {63'h0, done}, 64'h0);
    check("t3_idle", {63'h0, idle}, 64'h1);
    send_byte(8'h5A, 1'b1);
    check("t3_buffer", buffer, 64'h0);

    // 4: bad stop bit dropped, frame_err sticky
    d0 = done_cnt;
    arm(4'd2);
    send_byte(8'h55, 1'b0);
    check("t4_ferr_mid", {63'h0, frame_err}, 64'h1);
    check("t4_buf_mid", buffer, 64'h0);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    check("t4_buffer", buffer, 64'h6677);
    check("t4_ferr", {63'h0, frame_err}, 64'h1);
    check("t4_done_once", 64'(done_cnt - d0), 64'd1);

    // 5: idle bytes discarded; mid-frame trig ignored
    d0 = done_cnt;
    send_byte(8'h12, 1'b1);
    check("t5_idle_discard", buffer, 64'h6677);
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    arm(4'd1);
    check("t5_ferr_clr", {63'h0, frame_err}, 64'h0);
    send_byte(8'h34, 1'b1);
    check("t5_buffer", buffer, 64'h34);
    d0 = done_cnt;
    arm(4'd2);
    send_byte(8'h11, 1'b1);
    arm(4'd5);
    send_byte(8'h22, 1'b1);
    check("t5_retrig_buffer", buffer, 64'h1122);
    check("t5_retrig_done", 64'(done_cnt - d0), 64'd1);

    // clamp: num = 15 behaves as 8
    d0 = done_cnt;
    arm(4'd15);
    for (int i = 0; i < 8; i++) send_byte(8'hF0 + 8'(i), 1'b1);
    check("clamp_buffer", buffer, 64'hF0F1_F2F3_F4F5_F6F7);
    check("clamp_done", 64'(done_cnt - d0), 64'd1);

    // 6: reset mid-byte
    arm(4'd4);
    send_byte(8'hAB, 1'b1);
    check("t6_partial", buffer, 64'hAB);
    RX = 1'b0;
    repeat (3 * CPB) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    check("t6_rst_buffer", buffer, 64'h0);
    check("t6_rst_done", {63'h0, done}, 64'h0);
    check("t6_rst_ferr", {63'h0, frame_err}, 64'h0);
    check("t6_rst_idle", {63'h0, idle}, 64'h0);
    RX = 1'b1;
    repeat (2 * CPB) @(posedge Clock);
    #1;
    Reset = 1'b1;
    repeat (2 * CPB) @(posedge Clock);
    d0 = done_cnt;
    arm(4'd1);
    send_byte(8'h9F, 1'b1);
    check("t6_buffer", buffer, 64'h9F);
    check("t6_done_once", 64'(done_cnt - d0), 64'd1);

`ifdef UART_N_RX_TIMEOUT_EN
    d0 = done_cnt;
    arm(4'd2);
    send_byte(8'hEE, 1'b1);
    check("tmo_early", {63'h0, timeout}, 64'h0);
    repeat (300) @(posedge Clock);
    #1;
    check("tmo_flag", {63'h0, timeout}, 64'h1);
    check("tmo_buffer", buffer, 64'hEE);
    check("tmo_done", 64'(done_cnt - d0), 64'd1);
    check("tmo_idle", {63'h0, idle}, 64'h1);
    arm(4'd0);
    check("tmo_clr", {63'h0, timeout}, 64'h0);
    repeat (4) @(posedge Clock);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_n_rx.md
Name: uart_n_rx

Overview:
- Multi-byte serial receiver; the receive-side counterpart of the team's N-byte UART transmitter.
- Once armed by a rising edge on trig_in, it collects num bytes (1..8) from the RX line and packs them into a 64-bit word.
- Packing matches the transmitter's ordering: the first byte received is the most significant populated byte.
- Sits between the RX pin and the alarm controller's command decoder.

Parameters:
- CLKS_PER_BIT, 434, Clock cycles per UART bit (50 MHz / 115200); minimum 4.
- TIMEOUT_CYCLES, 65535, inter-byte timeout in Clock cycles (used only with the optional feature).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous active-low reset.
- RX  in  1  serial input; idles high; asynchronous to Clock.
- num  in  4  number of bytes to receive; sampled on arm.
- trig_in  in  1  arm request; rising-edge detected internally.
- buffer  out  64  received bytes, right-aligned.
- done  out  1  one-cycle pulse when the frame is complete.
- frame_err  out  1  sticky flag: at least one byte had a bad stop bit in the current frame.
- idle  out  1  Reset & (state == S_IDLE).

Behaviour:
- Interface: one clock (Clock); reset is asynchronous and active-low (Reset).
- Reset values: buffer=0, done=0, frame_err=0, state=S_IDLE, and the trig_in edge-detector register=0. idle reads 0 while Reset is low.
- trig edge: trig = trig_in & ~pre_trig, with pre_trig registered.
- RX synchronisation: two-flop synchroniser on RX inside the sub-module.
- Byte receiver (sub-module) flow:
  - Detect a falling edge.
  - Recheck the start bit at half a bit time; if RX is high, it is a glitch, so return to hunt.
  - Sample 8 data bits, LSB first, at bit centres.
  - Sample the stop bit.
  - Pulse valid for 1 cycle with data[7:0] and ferr (stop bit == 0).
  - Re-hunt immediately after the stop-bit sample.
- States:
  - S_IDLE: on trig, load tarn <= min(num, 8), clear buffer to 0, clear frame_err, and go to S_RECV. Bytes arriving in S_IDLE are discarded. A valid coincident with trig is discarded.
  - S_RECV, if tarn == 0: go to S_DONE (covers num == 0).
  - S_RECV, on valid & ~ferr: buffer <= {buffer[55:0], data}; tarn <= tarn - 1.
  - S_RECV, on valid & ferr: set frame_err and drop the byte; tarn is unchanged and the byte is not counted.
  - S_DONE: assert done for exactly 1 cycle, then go to S_IDLE. buffer holds its value until the next arm.
- Resulting layout: after N bytes, the first byte sits at buffer[8N-1:8N-8], the last at buffer[7:0], and the upper bits are 0.
- trig while not in S_IDLE: ignored, no restart.
- num > 8: clamped to 8.
- Latency: done rises 2 cycles after the valid of the final byte (S_RECV to S_DONE to the pulse registered), and rises 2 cycles after arm when num == 0.
- Reset mid-frame: everything returns to reset values immediately; the partial byte is lost.
- Arithmetic: tarn is 4 bits; the decrement never wraps because it is guarded by tarn != 0.

Optional Feature:
- Macro: UART_N_RX_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in S_RECV once at least one byte has been accepted; it resets on every valid.
  - On reaching TIMEOUT_CYCLES: abort to S_DONE, pulse done, and assert an extra output port timeout (1 bit, sticky until the next arm).
  - buffer holds the bytes received so far.
- Undefined: no counter and no timeout port; S_RECV waits indefinitely.

Decomposition:
- Shared package holds:
  - state encodings S_IDLE=2'b00, S_RECV=2'b01, S_DONE=2'b10;
  - MAX_BYTES=8;
  - the default CLKS_PER_BIT constant shared with the transmit path.
- One sub-module: uart_read_d (synchroniser plus single-byte receiver with ports Clock, Reset, RX, valid, data, ferr). It is the receive-side peer of the existing byte writer.

Test Plan (CLKS_PER_BIT=8):
1. num=3, arm, send 0xA1, 0xB2, 0xC3 -> done pulses once; buffer=64'h0000_0000_00A1_B2C3; frame_err=0; idle=1 afterwards.
2. num=8, send 0x01..0x08 -> buffer=64'h0102_0304_0506_0708.
3. num=0, arm -> done 2 cycles after the arm edge; buffer=0; no RX activity is consumed.
4. num=2, send 0x55 with stop=0, then 0x66, 0x77 -> buffer=64'h6677; frame_err=1.
5. Send 0x12 while idle, then arm with num=1 and send 0x34 -> buffer=64'h34. A second trig_in edge mid-frame has no effect.
6. Assert Reset mid-byte in frame (num=4) -> all outputs 0; a fresh arm with num=1 and 0x9F gives buffer=64'h9F. With UART_N_RX_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, num=2 and only 0xEE sent -> done and timeout; buffer=64'hEE.
